// File: rtl/vdma_reset_sequencer.sv
// Power-on / soft-reset sequencer for the VDMA core and FIFO resets (aclk domain).
// Define VDMA_RST_SEQ_TIMEOUT_EN to bound the QUIESCE wait and enable the sticky timeout flag.
module vdma_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned FIFO_SETTLE_CYCLES = 8,
`ifdef VDMA_RST_SEQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
`endif
  parameter int unsigned CNT_W              = 16
) (
  input  logic aclk_i,
  input  logic aclk_rstn_i,
  input  logic soft_reset_req_i,
  input  logic axi_idle_i,
  output logic stop_req_o,
  output logic fifo_rstn_o,
  output logic vdma_ip_rstn_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_HOLD,
    S_SETTLE,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(FIFO_SETTLE_CYCLES - 1);
`ifdef VDMA_RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             stop_q, stop_d;
  logic             fifo_rstn_q, fifo_rstn_d;
  logic             ip_rstn_q, ip_rstn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef VDMA_RST_SEQ_TIMEOUT_EN
  logic             timeout_q, timeout_set;
`endif

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
`ifdef VDMA_RST_SEQ_TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (soft_reset_req_i) state_d = S_QUIESCE;
      end
      S_QUIESCE: begin
`ifdef VDMA_RST_SEQ_TIMEOUT_EN
        if (axi_idle_i) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = S_HOLD;
          cnt_d       = '0;
          timeout_set = 1'b1;
        end
`else
        cnt_d = '0;
        if (axi_idle_i) state_d = S_HOLD;
`endif
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they change on the same edge as the state.
    stop_d      = 1'b1;
    fifo_rstn_d = 1'b1;
    ip_rstn_d   = 1'b1;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    case (state_d)
      S_IDLE: begin
        stop_d = 1'b0;
        busy_d = 1'b0;
      end
      S_HOLD: begin
        fifo_rstn_d = 1'b0;
        ip_rstn_d   = 1'b0;
      end
      S_SETTLE: ip_rstn_d = 1'b0;
      S_DONE:   done_d    = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
    if (!aclk_rstn_i) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      stop_q      <= 1'b1;
      fifo_rstn_q <= 1'b0;
      ip_rstn_q   <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_q      <= stop_d;
      fifo_rstn_q <= fifo_rstn_d;
      ip_rstn_q   <= ip_rstn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef VDMA_RST_SEQ_TIMEOUT_EN
  // Sticky until the next hard reset; soft sequences never clear it.
  always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
    if (!aclk_rstn_i)     timeout_q <= 1'b0;
    else if (timeout_set) timeout_q <= 1'b1;
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign stop_req_o     = stop_q;
  assign fifo_rstn_o    = fifo_rstn_q;
  assign vdma_ip_rstn_o = ip_rstn_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_vdma_reset_sequencer.sv
// Self-checking bench for vdma_reset_sequencer: directed scenarios plus random traffic
// against a phase-plan reference model.
module tb_vdma_reset_sequencer;

  localparam int HOLD_CYC   = 16;
  localparam int SETTLE_CYC = 8;
`ifdef VDMA_RST_SEQ_TIMEOUT_EN
  localparam int TO_CYC     = 32;
  localparam int QWAIT      = 20;
`else
  localparam int QWAIT      = 50;
`endif

  // Expected output vectors, ordered {busy, stop, fifo_rstn, ip_rstn, done}.
  localparam logic [4:0] O_IDLE   = 5'b00110;
  localparam logic [4:0] O_QUI    = 5'b11110;
  localparam logic [4:0] O_HOLD   = 5'b11000;
  localparam logic [4:0] O_SETTLE = 5'b11100;
  localparam logic [4:0] O_DONE   = 5'b11111;

  logic aclk_i = 1'b0;
  logic aclk_rstn_i;
  logic soft_reset_req_i;
  logic axi_idle_i;
  logic stop_req_o, fifo_rstn_o, vdma_ip_rstn_o, busy_o, done_o, timeout_o;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: a sequence is a fixed plan of output phases replayed one per clock.
  logic [4:0] exp_o;
  logic [4:0] plan[$];
  bit         quiescing;
  int         q_cycles;
  bit         exp_timeout;

  vdma_reset_sequencer #(
    .RST_HOLD_CYCLES    (HOLD_CYC),
    .FIFO_SETTLE_CYCLES (SETTLE_CYC),
`ifdef VDMA_RST_SEQ_TIMEOUT_EN
    .TIMEOUT_CYCLES     (TO_CYC),
`endif
    .CNT_W              (16)
  ) dut (
    .aclk_i           (aclk_i),
    .aclk_rstn_i      (aclk_rstn_i),
    .soft_reset_req_i (soft_reset_req_i),
    .axi_idle_i       (axi_idle_i),
    .stop_req_o       (stop_req_o),
    .fifo_rstn_o      (fifo_rstn_o),
    .vdma_ip_rstn_o   (vdma_ip_rstn_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .timeout_o        (timeout_o)
  );

  always #5 aclk_i = ~aclk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] dut_outs();
    return {busy_o, stop_req_o, fifo_rstn_o, vdma_ip_rstn_o, done_o, timeout_o};
  endfunction

  function automatic void load_plan();
    plan.delete();
    repeat (HOLD_CYC)   plan.push_back(O_HOLD);
    repeat (SETTLE_CYC) plan.push_back(O_SETTLE);
    plan.push_back(O_DONE);
    plan.push_back(O_IDLE);
  endfunction

  function automatic void model_reset();
    load_plan();
    exp_o       = plan.pop_front();
    quiescing   = 1'b0;
    q_cycles    = 0;
    exp_timeout = 1'b0;
  endfunction

  function automatic void model_edge(input logic req, input logic idle);
    if (plan.size() > 0) begin
      exp_o = plan.pop_front();
    end else if (quiescing) begin
      q_cycles++;
      if (idle) begin
        load_plan();
        exp_o     = plan.pop_front();
        quiescing = 1'b0;
      end
`ifdef VDMA_RST_SEQ_TIMEOUT_EN
      else if (q_cycles == TO_CYC) begin
        load_plan();
        exp_o       = plan.pop_front();
        quiescing   = 1'b0;
        exp_timeout = 1'b1;
      end
`endif
    end else if (req) begin
      exp_o     = O_QUI;
      quiescing = 1'b1;
      q_cycles  = 0;
    end
  endfunction

  // Drive inputs, clock once, advance the model and compare on the falling edge.
  task automatic cycle(input logic req, input logic idle);
    soft_reset_req_i = req;
    axi_idle_i       = idle;
    @(posedge aclk_i);
    model_edge(req, idle);
    @(negedge aclk_i);
    check("outs", 32'(dut_outs()), 32'({exp_o, exp_timeout}));
  endtask

  // Called just after a falling edge: assert reset mid-cycle and check that it acts without a clock.
  task automatic async_reset();
    #2;
    aclk_rstn_i      = 1'b0;
    soft_reset_req_i = 1'b0;
    #1;
    check("arst_outs", 32'(dut_outs()), 32'({O_HOLD, 1'b0}));
    model_reset();
    repeat (2) @(posedge aclk_i);
    @(negedge aclk_i);
    #2;
    aclk_rstn_i = 1'b1;
  endtask

  task automatic power_on_run();
    int done_per = 0;
    int idle_per = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle(1'b0, 1'b1);
      if (done_o && done_per == 0) done_per = k + 1;
      if (!busy_o && idle_per == 0) idle_per = k + 1;
    end
    check("por_done_period", 32'(done_per), 32'(HOLD_CYC + SETTLE_CYC + 1));
    check("por_idle_period", 32'(idle_per), 32'(HOLD_CYC + SETTLE_CYC + 2));
  endtask

  initial begin
    int done_per, stop_per, n_done, stall_left;
    logic req, idle;

    aclk_rstn_i      = 1'b0;
    soft_reset_req_i = 1'b0;
    axi_idle_i       = 1'b1;
    #12;
    check("rst_fifo_rstn", 32'(fifo_rstn_o), 32'd0);
    check("rst_ip_rstn",   32'(vdma_ip_rstn_o), 32'd0);
    check("rst_stop",      32'(stop_req_o), 32'd1);
    check("rst_busy",      32'(busy_o), 32'd1);
    check("rst_done",      32'(done_o), 32'd0);
    check("rst_timeout",   32'(timeout_o), 32'd0);
    model_reset();
    @(negedge aclk_i);
    #2;
    aclk_rstn_i = 1'b1;

    power_on_run();

    // Soft reset with the AXI master already idle.
    cycle(1'b1, 1'b1);
    check("soft_stop_rise", 32'(stop_req_o), 32'd1);
    done_per = 0;
    stop_per = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle(1'b0, 1'b1);
      if (done_o && done_per == 0) done_per = k + 1;
      if (!stop_req_o && stop_per == 0) stop_per = k + 1;
    end
    check("soft_done_period", 32'(done_per), 32'(1 + HOLD_CYC + SETTLE_CYC + 1));
    check("soft_stop_drop",   32'(stop_per), 32'(1 + HOLD_CYC + SETTLE_CYC + 2));

    // Quiesce wait: resets stay released until the master drains.
    cycle(1'b1, 1'b0);
    repeat (QWAIT) cycle(1'b0, 1'b0);
    check("quiesce_fifo_high", 32'(fifo_rstn_o), 32'd1);
    check("quiesce_stop",      32'(stop_req_o), 32'd1);
    cycle(1'b0, 1'b1);
    check("quiesce_hold_entry", 32'(fifo_rstn_o), 32'd0);
    repeat (30) cycle(1'b0, 1'b1);

    // Requests during HOLD and DONE are dropped.
    n_done = 0;
    cycle(1'b1, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      cycle(k == 5 || k == 1 + HOLD_CYC + SETTLE_CYC + 1, 1'b1);
      if (done_o) n_done++;
    end
    check("dropped_done_count", 32'(n_done), 32'd1);
    check("dropped_idle",       32'(busy_o), 32'd0);

    // Hard reset in the middle of SETTLE, then a full power-on sequence.
    cycle(1'b1, 1'b1);
    repeat (20) cycle(1'b0, 1'b1);
    check("pre_arst_ip_rstn", 32'(vdma_ip_rstn_o), 32'd0);
    async_reset();
    power_on_run();

`ifdef VDMA_RST_SEQ_TIMEOUT_EN
    begin
      int hold_per = 0;
      cycle(1'b1, 1'b0);
      for (int k = 1; k <= 40; k++) begin
        cycle(1'b0, 1'b0);
        if (!fifo_rstn_o && hold_per == 0) hold_per = k + 1;
      end
      check("timeout_hold_period", 32'(hold_per), 32'(TO_CYC + 1));
      repeat (30) cycle(1'b0, 1'b0);
      check("timeout_sticky", 32'(timeout_o), 32'd1);
      check("timeout_idle",   32'(busy_o), 32'd0);
    end
`else
    cycle(1'b1, 1'b0);
    repeat (2000) cycle(1'b0, 1'b0);
    check("no_timeout_busy", 32'(busy_o), 32'd1);
    check("no_timeout_flag", 32'(timeout_o), 32'd0);
    cycle(1'b0, 1'b1);
    repeat (30) cycle(1'b0, 1'b1);
    check("no_timeout_done", 32'(busy_o), 32'd0);
`endif

    // Random traffic: sparse requests, AXI stalls of random length, rare hard resets.
    stall_left = 0;
    for (int i = 0; i < 1500; i++) begin
      req = ($urandom_range(0, 11) == 0);
      if (stall_left > 0) begin
        idle = 1'b0;
        stall_left--;
      end else begin
        idle = 1'b1;
        if ($urandom_range(0, 5) == 0) stall_left = $urandom_range(1, 60);
      end
      if ($urandom_range(0, 399) == 0) async_reset();
      cycle(req, idle);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vdma_reset_sequencer.md
Name: vdma_reset_sequencer

Overview:
- Single-clock controller that sequences VDMA IP resets on power-up and on software request.
- Its outputs drive the vdma_ip_rstn and fifo_rstn inputs of the VDMA reset-distribution block.
- On a soft-reset request it first quiesces the AXI master, then asserts resets for a fixed hold time, then releases FIFO reset before core reset.
- It lives in the aclk domain and reports busy/done/timeout status to the register block.

Parameters:
- RST_HOLD_CYCLES, 16, cycles both resets are held low (>=1)
- FIFO_SETTLE_CYCLES, 8, cycles between FIFO reset release and core reset release (>=1)
- TIMEOUT_CYCLES, 1024, maximum QUIESCE wait before a forced reset (used only with the optional feature)
- CNT_W, 16, counter width; must hold max(all cycle parameters)

Ports:
- aclk_i  in  1  system/AXI clock
- aclk_rstn_i  in  1  asynchronous active-low reset
- soft_reset_req_i  in  1  single-cycle software reset request from the register block
- axi_idle_i  in  1  high when the AXI master has no outstanding read/write bursts (already in aclk domain)
- stop_req_o  out  1  instructs the datapath to stop issuing new bursts
- fifo_rstn_o  out  1  active-low FIFO reset request
- vdma_ip_rstn_o  out  1  active-low VDMA core reset request
- busy_o  out  1  high whenever the state is not IDLE
- done_o  out  1  one-cycle pulse when a sequence completes
- timeout_o  out  1  sticky flag: QUIESCE timed out (tied 0 without the optional feature)

Behaviour:
- Reset values while aclk_rstn_i=0: state=HOLD, counter=0, fifo_rstn_o=0, vdma_ip_rstn_o=0, stop_req_o=1, busy_o=1, done_o=0, timeout_o=0.
- All outputs are registered; no combinational path from input to output.
- States: IDLE, QUIESCE, HOLD, SETTLE, DONE.
- Power-on: after reset deassertion, the block starts in HOLD and skips QUIESCE.
- IDLE:
  - Outputs: stop_req_o=0, fifo_rstn_o=1, vdma_ip_rstn_o=1, busy_o=0.
  - soft_reset_req_i=1 moves to QUIESCE on the next clock; stop_req_o=1 from that edge.
- QUIESCE:
  - Resets stay high, stop_req_o=1.
  - When axi_idle_i=1 is sampled, go to HOLD at the next edge and clear the counter.
  - If axi_idle_i is already 1 on entry, QUIESCE lasts exactly 1 cycle.
- HOLD:
  - fifo_rstn_o=0, vdma_ip_rstn_o=0 for exactly RST_HOLD_CYCLES cycles.
  - Then go to SETTLE and clear the counter.
- SETTLE:
  - fifo_rstn_o=1, vdma_ip_rstn_o=0 for exactly FIFO_SETTLE_CYCLES cycles.
  - Then go to DONE.
- DONE:
  - One cycle: vdma_ip_rstn_o=1, done_o=1, stop_req_o=1.
  - Next cycle: IDLE, stop_req_o=0.
- Request handling:
  - soft_reset_req_i is accepted only in IDLE.
  - Requests in QUIESCE, HOLD, SETTLE or DONE are dropped, with no queued second sequence.
- Counter:
  - Counts up from 0 and saturates at all-ones.
  - Compare against parameter minus 1.
- timeout_o clears only on aclk_rstn_i.
- Asynchronous reset at any point (including mid-HOLD) returns immediately to the reset values above; a power-on sequence follows.
- Soft-reset total latency (request to done_o) with axi_idle_i=1: 1 (QUIESCE) + RST_HOLD_CYCLES + FIFO_SETTLE_CYCLES + 1 cycles after the request edge.

Optional Feature:
- Macro: VDMA_RST_SEQ_TIMEOUT_EN.
- Defined:
  - QUIESCE counts cycles.
  - If axi_idle_i is still 0 after TIMEOUT_CYCLES cycles in QUIESCE, go to HOLD anyway and set timeout_o=1 (sticky).
  - If axi_idle_i=1 on the same cycle the count expires, that is a normal exit and timeout_o stays 0.
- Undefined:
  - QUIESCE waits indefinitely for axi_idle_i.
  - timeout_o is constant 0 and there is no timeout counter logic.

Test Plan:
- Power-on, defaults: release aclk_rstn_i -> both resets low 16 cycles; fifo_rstn_o high, vdma_ip_rstn_o low for 8 more cycles; done_o pulse at cycle 25; busy_o low from cycle 26.
- Soft reset, idle AXI: axi_idle_i=1, 1-cycle soft_reset_req_i -> stop_req_o high next edge; HOLD 16 cycles; SETTLE 8 cycles; done_o 26 cycles after the request; stop_req_o drops the cycle after done_o.
- Quiesce wait: axi_idle_i=0 for 50 cycles after the request -> resets stay high, stop_req_o=1 throughout; HOLD begins the edge after axi_idle_i rises.
- Dropped request: pulse soft_reset_req_i during HOLD and again during DONE -> exactly one done_o; block returns to IDLE with no second sequence.
- Async reset mid-SETTLE: assert aclk_rstn_i low -> fifo_rstn_o=0, vdma_ip_rstn_o=0 immediately; after release, a full power-on sequence runs.
- Timeout (macro defined, TIMEOUT_CYCLES=32): axi_idle_i held 0 -> HOLD entered after 32 QUIESCE cycles; timeout_o=1 and stays 1 after done_o. With the macro undefined, the block is still in QUIESCE after 2000 cycles and timeout_o=0.
